// File: rtl/cpu54_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu54_wb_arbiter_pkg
// Brief    : Shared widths, arbiter state encoding and zero-register constant.
// Revision : 1.0 - initial release
// ============================================================================
package cpu54_wb_arbiter_pkg;

    localparam int c_dw       = 32;
    localparam int c_aw       = 5;
    localparam int c_zero_reg = 0;

    localparam logic [0:0] PRI_A = 1'b0;
    localparam logic [0:0] PRI_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cpu54_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : cpu54_wb_scoreboard
// Brief    : Per-register pending bits with set-over-clear priority and lookup.
// Revision : 1.0 - initial release
// ============================================================================
module cpu54_wb_scoreboard
    import cpu54_wb_arbiter_pkg::*;
#(
    parameter int AW = c_aw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_mark_valid,
    input  logic [AW-1:0] i_mark_addr,
    input  logic          i_clr_valid,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_rs_addr,
    input  logic [AW-1:0] i_rt_addr,
    output logic          o_rs_pending,
    output logic          o_rt_pending
);

    localparam int c_nreg = 2 ** AW;

    logic [c_nreg-1:0] r_pending;
    logic [c_nreg-1:0] w_set_mask;
    logic [c_nreg-1:0] w_clr_mask;

    // The zero register can never become pending.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_mark_valid && (i_mark_addr != AW'(c_zero_reg)))
            w_set_mask[i_mark_addr] = 1'b1;
        if (i_clr_valid)
            w_clr_mask[i_clr_addr] = 1'b1;
    end

    // Set applied after clear: a newer producer outranks the retiring one.
    always_ff @(posedge clk) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign o_rs_pending = r_pending[i_rs_addr];
    assign o_rt_pending = r_pending[i_rt_addr];

endmodule
`default_nettype wire

// File: rtl/cpu54_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu54_wb_arbiter
// Brief    : Round-robin two-requester writeback arbiter with register
//            scoreboard. Optional operand bypass via CPU54_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu54_wb_arbiter
    import cpu54_wb_arbiter_pkg::*;
#(
    parameter int DW = c_dw,
    parameter int AW = c_aw
) (
    input  logic          clock_in,
    input  logic          reset_signal,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          mark_valid,
    input  logic [AW-1:0] mark_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
`ifdef CPU54_WB_BYPASS_EN
    ,
    output logic          rs_fwd_valid,
    output logic [DW-1:0] rs_fwd_data,
    output logic          rt_fwd_valid,
    output logic [DW-1:0] rt_fwd_data
`endif
);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_grant;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_data;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          w_rs_pending;
    logic          w_rt_pending;

    // A lone requester always wins; the state only breaks ties.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!reset_signal) begin
            if (a_valid && (!b_valid || (r_state == PRI_A)))
                w_grant_a = 1'b1;
            else if (b_valid)
                w_grant_b = 1'b1;
        end
    end

    assign w_grant    = w_grant_a | w_grant_b;
    assign w_gnt_addr = w_grant_b ? b_addr : a_addr;
    assign w_gnt_data = w_grant_b ? b_data : a_data;
    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant_a)
            w_state_nxt = PRI_B;
        else if (w_grant_b)
            w_state_nxt = PRI_A;
    end

    always_ff @(posedge clock_in) begin
        if (reset_signal) begin
            r_state   <= PRI_A;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Writes to the zero register complete the handshake but are dropped.
            r_wr_en <= w_grant && (w_gnt_addr != AW'(c_zero_reg));
            if (w_grant) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    cpu54_wb_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk          (clock_in),
        .rst          (reset_signal),
        .i_mark_valid (mark_valid),
        .i_mark_addr  (mark_addr),
        .i_clr_valid  (w_grant),
        .i_clr_addr   (w_gnt_addr),
        .i_rs_addr    (rs_addr),
        .i_rt_addr    (rt_addr),
        .o_rs_pending (w_rs_pending),
        .o_rt_pending (w_rt_pending)
    );

`ifdef CPU54_WB_BYPASS_EN
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit     = r_wr_en && (r_wr_addr == rs_addr) && (r_wr_addr != AW'(c_zero_reg));
    assign w_rt_hit     = r_wr_en && (r_wr_addr == rt_addr) && (r_wr_addr != AW'(c_zero_reg));
    assign rs_fwd_valid = w_rs_hit;
    assign rt_fwd_valid = w_rt_hit;
    assign rs_fwd_data  = r_wr_data;
    assign rt_fwd_data  = r_wr_data;
    assign rs_busy      = w_rs_pending & ~w_rs_hit;
    assign rt_busy      = w_rt_pending & ~w_rt_hit;
`else
    assign rs_busy = w_rs_pending;
    assign rt_busy = w_rt_pending;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu54_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu54_wb_arbiter
// Brief    : Directed self-checking bench for cpu54_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu54_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock_in;
    logic          reset_signal;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, mark_addr, rs_addr, rt_addr, wr_addr;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          mark_valid, rs_busy, rt_busy, wr_en;
`ifdef CPU54_WB_BYPASS_EN
    logic          rs_fwd_valid, rt_fwd_valid;
    logic [DW-1:0] rs_fwd_data, rt_fwd_data;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    cpu54_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clock_in     (clock_in),
        .reset_signal (reset_signal),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .mark_valid   (mark_valid),
        .mark_addr    (mark_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
`ifdef CPU54_WB_BYPASS_EN
        ,
        .rs_fwd_valid (rs_fwd_valid),
        .rs_fwd_data  (rs_fwd_data),
        .rt_fwd_valid (rt_fwd_valid),
        .rt_fwd_data  (rt_fwd_data)
`endif
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset_signal = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd1; b_addr = 5'd2;
        a_data = 32'h1; b_data = 32'h2;
        mark_valid = 1'b1; mark_addr = 5'd4; rs_addr = 5'd4; rt_addr = 5'd4;
        #1;
        total_cnt++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL reset_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) $display("FAIL reset_wr: got en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data); else pass_cnt++;
        total_cnt++; if (rs_busy !== 1'b0) $display("FAIL reset_pending: got rs_busy=%b want 0", rs_busy); else pass_cnt++;
        reset_signal = 1'b0; a_valid = 1'b0; b_valid = 1'b0; mark_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        #1;
        total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL single_a_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready); else pass_cnt++;
        tick();
        a_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h11) $display("FAIL single_a_wr: got en=%b addr=%0d data=%h want 1/3/11", wr_en, wr_addr, wr_data); else pass_cnt++;
        tick();
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL single_a_pulse: got wr_en=%b want 0", wr_en); else pass_cnt++;
    endtask

    // Starts in PRI_B after the single A grant.
    task automatic test_round_robin();
        logic [3:0] exp_b;
        exp_b = 4'b0101;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hA4;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hB5;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (b_ready !== exp_b[i] || a_ready !== ~exp_b[i]) $display("FAIL rr_grant%0d: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, ~exp_b[i], exp_b[i]); else pass_cnt++;
            tick();
            total_cnt++; if (wr_en !== 1'b1 || wr_addr !== (exp_b[i] ? 5'd5 : 5'd4)) $display("FAIL rr_wr%0d: got en=%b addr=%0d want 1/%0d", i, wr_en, wr_addr, exp_b[i] ? 5 : 4); else pass_cnt++;
        end
        a_valid = 1'b0;
        #1;
        total_cnt++; if (b_ready !== 1'b1 || a_ready !== 1'b0) $display("FAIL lone_b: got a=%b b=%b want a=0 b=1", a_ready, b_ready); else pass_cnt++;
        tick();
        b_valid = 1'b0;
        total_cnt++; if (wr_data !== 32'hB5) $display("FAIL lone_b_data: got %h want b5", wr_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_scoreboard();
        mark_valid = 1'b1; mark_addr = 5'd7;
        tick();
        mark_valid = 1'b0; rs_addr = 5'd7;
        #1;
        total_cnt++; if (rs_busy !== 1'b1) $display("FAIL sb_mark7: got rs_busy=%b want 1", rs_busy); else pass_cnt++;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        #1;
        total_cnt++; if (rs_busy !== 1'b1) $display("FAIL sb_before_clr: got rs_busy=%b want 1", rs_busy); else pass_cnt++;
        tick();
        b_valid = 1'b0;
        total_cnt++; if (rs_busy !== 1'b0 || wr_addr !== 5'd7) $display("FAIL sb_clr7: got rs_busy=%b addr=%0d want 0/7", rs_busy, wr_addr); else pass_cnt++;
        tick();
    endtask

    task automatic test_set_clear_same();
        mark_valid = 1'b1; mark_addr = 5'd9;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        tick();
        mark_valid = 1'b0; a_valid = 1'b0;
        tick();
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        total_cnt++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1) $display("FAIL set_wins: got rs=%b rt=%b want 1/1", rs_busy, rt_busy); else pass_cnt++;
        mark_valid = 1'b1; mark_addr = 5'd0;
        tick();
        mark_valid = 1'b0; rs_addr = 5'd0;
        #1;
        total_cnt++; if (rs_busy !== 1'b0) $display("FAIL zero_never_pending: got rs_busy=%b want 0", rs_busy); else pass_cnt++;
    endtask

    task automatic test_zero_and_withdraw();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        #1;
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL zero_handshake: got a_ready=%b want 1", a_ready); else pass_cnt++;
        tick();
        a_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL zero_wr_en: got wr_en=%b want 0", wr_en); else pass_cnt++;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        #2;
        b_valid = 1'b0;
        tick();
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL withdraw: got wr_en=%b want 0", wr_en); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        mark_valid = 1'b1; mark_addr = 5'd12;
        tick();
        mark_valid = 1'b0;
        reset_signal = 1'b1;
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
        #1;
        total_cnt++; if (a_ready !== 1'b0) $display("FAIL mid_reset_ready: got a_ready=%b want 0", a_ready); else pass_cnt++;
        tick();
        reset_signal = 1'b0; a_valid = 1'b0;
        rs_addr = 5'd12; rt_addr = 5'd9;
        #1;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL mid_reset_wr: got wr_en=%b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) $display("FAIL mid_reset_pending: got rs=%b rt=%b want 0/0", rs_busy, rt_busy); else pass_cnt++;
        a_valid = 1'b1; a_addr = 5'd1; b_valid = 1'b1; b_addr = 5'd2;
        #1;
        total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL mid_reset_pri_a: got a=%b b=%b want a=1 b=0", a_ready, b_ready); else pass_cnt++;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        mark_valid = 1'b1; mark_addr = 5'd6;
        tick();
        mark_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'hABCD;
        rt_addr = 5'd6;
        tick();
        a_valid = 1'b0;
        total_cnt++; if (rt_busy !== 1'b0 || wr_data !== 32'hABCD) $display("FAIL bypass_busy: got rt_busy=%b data=%h want 0/abcd", rt_busy, wr_data); else pass_cnt++;
`ifdef CPU54_WB_BYPASS_EN
        total_cnt++; if (rt_fwd_valid !== 1'b1 || rt_fwd_data !== 32'hABCD) $display("FAIL bypass_fwd: got valid=%b data=%h want 1/abcd", rt_fwd_valid, rt_fwd_data); else pass_cnt++;
        mark_valid = 1'b1; mark_addr = 5'd6;
        tick();
        mark_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h1234;
        mark_valid = 1'b1;
        tick();
        a_valid = 1'b0; mark_valid = 1'b0;
        total_cnt++; if (rt_busy !== 1'b0 || rt_fwd_valid !== 1'b1) $display("FAIL bypass_mask: got rt_busy=%b fwd=%b want 0/1", rt_busy, rt_fwd_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rt_busy !== 1'b1 || rt_fwd_valid !== 1'b0) $display("FAIL bypass_after: got rt_busy=%b fwd=%b want 1/0", rt_busy, rt_fwd_valid); else pass_cnt++;
`endif
    endtask

    initial begin
        reset_signal = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; mark_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        mark_addr = '0; rs_addr = '0; rt_addr = '0;
        test_reset();
        test_single_a();
        test_round_robin();
        test_scoreboard();
        test_set_clear_same();
        test_zero_and_withdraw();
        test_reset_mid();
        test_bypass();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu54_wb_arbiter.md
CPU54_WB_ARBITER -- requirements
Module: cpu54_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width; AW, default 5, register address width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock_in  in  1  sole clock; all state updates on posedge.
- reset_signal  in  1  synchronous reset, active-high.
- a_valid, a_ready  in/out  1/1  requester A (ALU writeback) handshake.
- a_addr, a_data  in  AW/DW  requester A destination register and value.
- b_valid, b_ready  in/out  1/1  requester B (load/mult-div writeback) handshake.
- b_addr, b_data  in  AW/DW  requester B destination register and value.
- mark_valid, mark_addr  in  1/AW  issue stage marks a register as pending.
- rs_addr, rt_addr  in  AW/AW  issue-stage source operand addresses.
- rs_busy, rt_busy  out  1/1  source operand has a pending write.
- wr_en, wr_addr, wr_data  out  1/AW/DW  registered regfile write port.

Function
REQ-003 A transfer on a requester SHALL occur in a cycle where its valid and ready are both high.
REQ-004 a_ready and b_ready SHALL be combinational from the valids and the priority state, and at most one SHALL be high in any cycle.
REQ-005 Arbitration SHALL be round-robin. It SHALL be a 2-state FSM: PRI_A (A wins a tie) and PRI_B (B wins a tie).
REQ-006 A grant to A SHALL move the FSM to PRI_B, and a grant to B SHALL move it to PRI_A. With no grant, the state SHALL hold.
REQ-007 A lone valid requester SHALL be granted in the same cycle, regardless of the FSM state.
REQ-008 The granted address and data SHALL appear on wr_addr/wr_data in the next cycle, with wr_en=1 for exactly one cycle (latency 1).
REQ-009 A granted transfer with address 0 SHALL complete the handshake but drive wr_en=0 in the following cycle.
REQ-010 A 32-bit pending vector SHALL hold one bit per register.
- A cycle with mark_valid sets pending[mark_addr] at the next posedge.
- A granted transfer clears pending[addr] at the next posedge.
REQ-011 A set and a clear of the same register in one cycle SHALL leave the bit set, because the newer producer wins.
REQ-012 pending[0] SHALL never be set.
REQ-013 rs_busy SHALL equal pending[rs_addr] and rt_busy SHALL equal pending[rt_addr], combinationally.
REQ-014 A transfer whose address is not pending SHALL still be written. No error SHALL be flagged.
REQ-015 The valid, addr and data inputs SHALL be sampled only in the grant cycle. A dropped valid SHALL simply withdraw the request.

Reset
REQ-016 While reset_signal is high at a posedge, all state SHALL be forced as follows:
- FSM to PRI_A.
- pending to 0.
- wr_en, wr_addr and wr_data to 0.
REQ-017 During a reset cycle, a_ready and b_ready SHALL be 0, and no transfer SHALL complete.
REQ-018 Reset asserted mid-operation SHALL discard any grant issued in that cycle and all pending bits.

Configuration
REQ-019 With the macro CPU54_WB_BYPASS_EN defined, the block SHALL add outputs rs_fwd_valid, rs_fwd_data, rt_fwd_valid and rt_fwd_data.
- When wr_en=1 and wr_addr equals rs_addr (rt_addr) and is non-zero, the matching fwd_valid SHALL be 1 and fwd_data SHALL be wr_data.
- In that case the matching busy output SHALL be 0.
REQ-020 Without CPU54_WB_BYPASS_EN, the forwarding ports SHALL be absent and busy SHALL follow REQ-013 only.

Structure
REQ-021 A shared package SHALL hold the following:
- the DW and AW constants;
- the PRI_A/PRI_B state encoding;
- the zero-register constant.
REQ-022 The pending vector, with its set/clear priority and busy lookup, SHALL be one sub-module, cpu54_wb_scoreboard. Arbitration and the write-port register SHALL stay in the top.

Verification
REQ-023 Reset, then a_valid=1 with a_addr=3, a_data=32'h11 -> a_ready=1 in the same cycle; next cycle wr_en=1, wr_addr=3, wr_data=32'h11; FSM=PRI_B.
REQ-024 Both valid for 4 cycles (A addr 4, B addr 5) -> grants go B, A, B, A starting from PRI_B, and exactly one wr_en pulse per cycle.
REQ-025 mark_valid with mark_addr=7, then rs_addr=7 -> rs_busy=1; B writes addr 7 -> rs_busy=0 one cycle after the grant.
REQ-026 In the same cycle mark_addr=9 and an A grant to addr 9 -> pending[9] stays 1; mark_addr=0 -> rs_busy for addr 0 stays 0.
REQ-027 A grant to addr 0 with data 32'hFFFF_FFFF -> handshake completes and wr_en stays 0. Reset asserted during a grant -> wr_en=0 and pending=0 next cycle.
REQ-028 With CPU54_WB_BYPASS_EN: pending addr 6 written by A with data 32'hABCD and rt_addr=6 -> in the write cycle, rt_fwd_valid=1, rt_fwd_data=32'hABCD and rt_busy=0.
